// File: rtl/enemy_patrol_if.sv
// enemy_patrol_if -- bundle between the game/level logic and one patrolling
// enemy controller.
//   master : drives game_state, player_x/player_y, player_falling and
//            background_offset; receives the enemy outputs.
//   slave  : the enemy controller (consumes inputs, drives outputs).
// Outputs: enemy_x_rel/enemy_y_rel (screen coords), is_right, visible,
// squished, collides (sticky hit), stomp (one-frame pulse).
interface enemy_patrol_if #(
  parameter int W = 18
);
  logic [1:0]   game_state;
  logic [W-1:0] player_x;
  logic [W-1:0] player_y;
  logic         player_falling;
  logic [W-1:0] background_offset;
  logic [W-1:0] enemy_x_rel;
  logic [W-1:0] enemy_y_rel;
  logic         is_right;
  logic         visible;
  logic         squished;
  logic         collides;
  logic         stomp;

  modport master (
    output game_state, player_x, player_y, player_falling, background_offset,
    input  enemy_x_rel, enemy_y_rel, is_right, visible, squished, collides, stomp
  );

  modport slave (
    input  game_state, player_x, player_y, player_falling, background_offset,
    output enemy_x_rel, enemy_y_rel, is_right, visible, squished, collides, stomp
  );
endinterface

// File: rtl/enemy_patrol.sv
// enemy_patrol -- one Goomba-style patrolling enemy.
// Waits (IDLE) until the level scrolls near its start point, then walks back
// and forth between LEFT_BOUND and RIGHT_BOUND. Player contact while walking
// is either a stomp (one-frame stomp pulse, squish for SQUISH_FRAMES frames,
// then removed) or a side hit (sticky collides flag).
// Ports:
//   frame_clk : frame-rate clock, state advances once per frame
//   Reset     : asynchronous active-high reset
//   bus       : enemy_patrol_if slave modport (player/scroll in, sprite and
//               status out). enemy_x_rel/enemy_y_rel are combinational.
module enemy_patrol #(
  parameter int W             = 18,
  parameter int START_X       = 5540,
  parameter int START_Y       = 408,
  parameter int LEFT_BOUND    = 5304,
  parameter int RIGHT_BOUND   = 5752,
  parameter int STEP          = 1,
  parameter int HALF_W        = 16,
  parameter int HIT_MARGIN    = 32,
  parameter int STOMP_DY      = 8,
  parameter int SQUISH_FRAMES = 30,
  parameter int SPAWN_DIST    = 700,
  parameter int START_RIGHT   = 0
) (
  input  logic          frame_clk,
  input  logic          Reset,
  enemy_patrol_if.slave bus
);

  localparam int CW = (SQUISH_FRAMES > 1) ? $clog2(SQUISH_FRAMES) : 1;

  localparam logic [W-1:0]        K_START_X  = W'(START_X);
  localparam logic [W-1:0]        K_START_Y  = W'(START_Y);
  localparam logic [W:0]          K_START_XE = (W+1)'(START_X);
  localparam logic [W:0]          K_SPAWN    = (W+1)'(SPAWN_DIST);
  localparam logic [W:0]          K_R_LIM    = (W+1)'(RIGHT_BOUND);
  localparam logic [W:0]          K_R_REACH  = (W+1)'(HALF_W + STEP);
  // Left test "x - HALF_W - STEP <= LEFT_BOUND" rewritten as
  // "x <= LEFT_BOUND + HALF_W + STEP" so it cannot underflow.
  localparam logic [W:0]          K_L_LIM    = (W+1)'(LEFT_BOUND + HALF_W + STEP);
  localparam logic [W-1:0]        K_X_MAX    = W'(RIGHT_BOUND - HALF_W);
  localparam logic [W-1:0]        K_X_MIN    = W'(LEFT_BOUND + HALF_W);
  localparam logic [W-1:0]        K_STEP     = W'(STEP);
  localparam logic [W:0]          K_HIT      = (W+1)'(HIT_MARGIN);
  localparam logic signed [W:0]   K_STOMP_DY = (W+1)'(STOMP_DY);
  localparam logic [CW-1:0]       K_SQ_LAST  = CW'(SQUISH_FRAMES - 1);
  localparam logic                K_RIGHT0   = (START_RIGHT != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WALK   = 2'd1,
    S_SQUISH = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic          right_q, right_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_q, hit_d;
  logic          stomp_q, stomp_d;

  logic [W-1:0]     x_rel_s;
  logic signed [W:0] dx_s, dy_s;
  logic [W:0]       abs_dx_s, abs_dy_s;
  logic             contact_s, stomp_hit_s, spawn_s;

  // Magnitude of a signed W+1 difference; the operands are zero-extended
  // W-bit values, so the most negative code never occurs.
  function automatic logic [W:0] abs_w(input logic signed [W:0] v);
    if (v[W]) begin
      abs_w = $unsigned(-v);
    end else begin
      abs_w = $unsigned(v);
    end
  endfunction

  // Screen-relative geometry and contact classification from registered x.
  always_comb begin
    x_rel_s     = x_q - bus.background_offset;
    dx_s        = $signed({1'b0, bus.player_x}) - $signed({1'b0, x_rel_s});
    dy_s        = $signed({1'b0, bus.player_y}) - $signed({1'b0, K_START_Y});
    abs_dx_s    = abs_w(dx_s);
    abs_dy_s    = abs_w(dy_s);
    contact_s   = (abs_dx_s <= K_HIT) && (abs_dy_s <= K_HIT);
    stomp_hit_s = contact_s && bus.player_falling && (dy_s <= -K_STOMP_DY);
    spawn_s     = ({1'b0, bus.background_offset} + K_SPAWN) >= K_START_XE;
  end

  // Next-state logic: spawn, patrol with bounce, contact, squish timer.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    right_d = right_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    stomp_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (spawn_s) begin
          state_d = S_WALK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WALK: begin
        if (stomp_hit_s) begin
          // Stomp has priority and freezes the position this frame.
          state_d = S_SQUISH;
          cnt_d   = {CW{1'b0}};
          stomp_d = 1'b1;
        end else begin
          if (contact_s) begin
            hit_d = 1'b1;
          end else begin
            hit_d = hit_q;
          end
          if (right_q) begin
            if (({1'b0, x_q} + K_R_REACH) >= K_R_LIM) begin
              x_d     = K_X_MAX;
              right_d = 1'b0;
            end else begin
              x_d = x_q + K_STEP;
            end
          end else begin
            if ({1'b0, x_q} <= K_L_LIM) begin
              x_d     = K_X_MIN;
              right_d = 1'b1;
            end else begin
              x_d = x_q - K_STEP;
            end
          end
        end
      end
      S_SQUISH: begin
        if (cnt_q == K_SQ_LAST) begin
          state_d = S_DEAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DEAD: begin
        state_d = S_DEAD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; leaving RUN behaves like a synchronous reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      x_q     <= K_START_X;
      right_q <= K_RIGHT0;
      cnt_q   <= {CW{1'b0}};
      hit_q   <= 1'b0;
      stomp_q <= 1'b0;
    end else if (bus.game_state != 2'b01) begin
      state_q <= S_IDLE;
      x_q     <= K_START_X;
      right_q <= K_RIGHT0;
      cnt_q   <= {CW{1'b0}};
      hit_q   <= 1'b0;
      stomp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      right_q <= right_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      stomp_q <= stomp_d;
    end
  end

  assign bus.enemy_x_rel = x_rel_s;
  assign bus.enemy_y_rel = K_START_Y;
  assign bus.is_right    = right_q;
  assign bus.visible     = (state_q == S_WALK) || (state_q == S_SQUISH);
  assign bus.squished    = (state_q == S_SQUISH);
  assign bus.collides    = hit_q;
  assign bus.stomp       = stomp_q;

endmodule

// File: tb/tb_enemy_patrol.sv
// Scoreboard bench for enemy_patrol: the stimulus side runs a frame-level
// reference model and queues the expected outputs; an independent monitor
// pops one entry per frame edge (or per async-reset sample) and compares.
module tb_enemy_patrol;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  logic mon_en    = 1'b0;
  logic chk_tog   = 1'b0;

  enemy_patrol_if #(.W(18)) bus ();

  enemy_patrol dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic        vis;
    logic        sq;
    logic        rt;
    logic        hit;
    logic        stp;
    logic [17:0] xr;
    logic [17:0] yr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: mode 0 waiting, 1 walking, 2 squashed, 3 gone.
  int m_mode, m_x, m_right, m_left, m_hit, m_stomp;
  int l_gs, l_px, l_py, l_pf, l_off;

  function automatic int wrap18(int v);
    return v & 32'h0003FFFF;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = 5540; m_right = 0; m_left = 0; m_hit = 0; m_stomp = 0;
  endtask

  task automatic model_step(int gs, int px, int py, int pf, int off);
    int xr, dx, dy;
    bit contact;
    if (gs != 1) begin
      model_reset();
    end else begin
      m_stomp = 0;
      case (m_mode)
        0: if (off + 700 >= 5540) m_mode = 1;
        1: begin
          xr = wrap18(m_x - off);
          dx = px - xr;
          dy = py - 408;
          contact = (dx <= 32) && (dx >= -32) && (dy <= 32) && (dy >= -32);
          if (contact && pf != 0 && dy <= -8) begin
            m_stomp = 1; m_mode = 2; m_left = 30;
          end else begin
            if (contact) m_hit = 1;
            if (m_right != 0) begin
              if (m_x + 17 >= 5752) begin m_x = 5736; m_right = 0; end
              else m_x = m_x + 1;
            end else begin
              if (m_x - 17 <= 5304) begin m_x = 5320; m_right = 1; end
              else m_x = m_x - 1;
            end
          end
        end
        2: begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 3;
        end
        default: ;
      endcase
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.vis = (m_mode == 1) || (m_mode == 2);
    e.sq  = (m_mode == 2);
    e.rt  = (m_right != 0);
    e.hit = (m_hit != 0);
    e.stp = (m_stomp != 0);
    e.xr  = 18'(wrap18(m_x - l_off));
    e.yr  = 18'd408;
    exp_q.push_back(e);
  endtask

  // Drive inputs now and queue what the next frame edge should produce.
  task automatic apply(int gs, int px, int py, int pf, int off);
    l_gs = gs; l_px = px; l_py = py; l_pf = pf; l_off = off;
    bus.game_state        = 2'(gs);
    bus.player_x          = 18'(px);
    bus.player_y          = 18'(py);
    bus.player_falling    = (pf != 0);
    bus.background_offset = 18'(off);
    model_step(gs, px, py, pf, off);
    push_exp();
  endtask

  task automatic frame(int gs, int px, int py, int pf, int off);
    @(negedge frame_clk);
    apply(gs, px, py, pf, off);
  endtask

  // Async reset between edges: sample while Reset is high, then resume.
  task automatic reset_pulse();
    @(negedge frame_clk);
    #1;
    Reset = 1'b1;
    model_reset();
    push_exp();
    chk_tog = ~chk_tog;
    #2;
    Reset = 1'b0;
    apply(l_gs, l_px, l_py, l_pf, l_off);
  endtask

  task automatic far(int n);
    for (int i = 0; i < n; i++) frame(1, 900, 0, 0, l_off);
  endtask

  // Leave RUN for a frame, then spawn and take one walking step.
  task automatic respawn();
    frame(0, 900, 0, 0, 4840);
    frame(1, 900, 0, 0, 4840);
    frame(1, 900, 0, 0, 4840);
  endtask

  // Monitor: compare DUT outputs against the next queued expectation.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge frame_clk or chk_tog);
      #1;
      if (mon_en) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty t=%0t: DUT output with no expectation queued", $time);
        end else begin
          e = exp_q.pop_front();
          got.vis = bus.visible;
          got.sq  = bus.squished;
          got.rt  = bus.is_right;
          got.hit = bus.collides;
          got.stp = bus.stomp;
          got.xr  = bus.enemy_x_rel;
          got.yr  = bus.enemy_y_rel;
          if (got !== e) begin
            n_bad++;
            $display("FAIL frame t=%0t got vis=%b sq=%b rt=%b hit=%b stomp=%b xr=%0d yr=%0d expected vis=%b sq=%b rt=%b hit=%b stomp=%b xr=%0d yr=%0d",
                     $time, got.vis, got.sq, got.rt, got.hit, got.stp, got.xr, got.yr,
                     e.vis, e.sq, e.rt, e.hit, e.stp, e.xr, e.yr);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Stimulus.
  initial begin
    int off, xr, px, py;
    model_reset();
    l_off = 4800;
    bus.game_state = 2'b00; bus.player_x = 18'd0; bus.player_y = 18'd0;
    bus.player_falling = 1'b0; bus.background_offset = 18'd4800;
    repeat (2) @(negedge frame_clk);
    mon_en = 1'b1;
    push_exp();
    chk_tog = ~chk_tog;
    #2;
    Reset = 1'b0;
    apply(1, 900, 0, 0, 4800);

    // Not yet in range, then spawn at offset 4840 (x_rel 700).
    for (int i = 0; i < 4; i++) frame(1, 900, 0, 0, 4800);
    frame(1, 900, 0, 0, 4840);

    // Long patrol covering both bounces, scrolling randomly, player away.
    for (int i = 0; i < 720; i++)
      frame(1, $urandom_range(0, 1000), 0, $urandom_range(0, 1), 4840 + $urandom_range(0, 400));

    // Side hit at x_rel 300, then the player leaves.
    off = m_x - 300;
    frame(1, 270, 408, 0, off);
    far(5);

    // Stomp, squish, dead, contact in dead state ignored.
    respawn();
    off = m_x - 300;
    frame(1, 305, 380, 1, off);
    far(32);
    frame(1, wrap18(m_x - off), 408, 0, off);
    frame(1, wrap18(m_x - off), 380, 1, off);

    // Boundary: dy=-8 and |dx|=32 stomps; dy=-7 only collides.
    respawn();
    off = m_x - 300;
    frame(1, 332, 400, 1, off);
    far(2);
    respawn();
    off = m_x - 300;
    frame(1, 268, 401, 1, off);
    far(2);

    // Leave RUN mid-squish (counter 10), then async reset mid-squish.
    respawn();
    off = m_x - 300;
    frame(1, 300, 380, 1, off);
    far(10);
    frame(0, 900, 0, 0, off);
    far(3);
    respawn();
    off = m_x - 300;
    frame(1, 300, 380, 1, off);
    far(10);
    reset_pulse();
    far(3);

    // Random episodes with the player hovering around the enemy.
    for (int ep = 0; ep < 25; ep++) begin
      respawn();
      for (int i = 0; i < 80; i++) begin
        off = 4840 + $urandom_range(0, 160);
        xr  = wrap18(m_x - off);
        if ($urandom_range(0, 3) == 0) begin
          px = xr + $urandom_range(0, 80) - 40;
          py = 408 + $urandom_range(0, 80) - 40;
        end else begin
          px = xr + 200;
          py = 100;
        end
        frame(1, px, py, $urandom_range(0, 1), off);
      end
    end

    @(posedge frame_clk);
    #3;
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, 0 required", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/enemy_patrol.md
Name: enemy_patrol

Overview:
- Parametrised patrolling-enemy controller: one instance per Goomba-style enemy in the level.
- Tracks the enemy's global X position and patrols between two level bounds.
- Spawns only when scrolled near the screen.
- Resolves player contact as either a stomp (enemy squished, then removed) or a hit (sticky player-damage flag).
- Outputs screen-relative coordinates to the sprite renderer and status to the game-state controller.

Parameters:
- W, 18, width of all position/offset buses.
- START_X, 5540, global X centre at reset/respawn.
- START_Y, 408, Y centre (constant, no gravity).
- LEFT_BOUND, 5304, leftmost global X the enemy's left edge may reach.
- RIGHT_BOUND, 5752, rightmost global X the enemy's right edge may reach.
- STEP, 1, pixels moved per frame while walking.
- HALF_W, 16, half sprite width.
- HIT_MARGIN, 32, contact box half-size (|dx| and |dy| both ≤ HIT_MARGIN means contact).
- STOMP_DY, 8, player Y must be at least this far above enemy Y for a stomp.
- SQUISH_FRAMES, 30, frames the squished sprite stays visible.
- SPAWN_DIST, 700, activate when START_X − background_offset ≤ SPAWN_DIST.
- START_RIGHT, 0, initial direction (1 = moving right).

Ports:
- frame_clk  in  1  frame-rate clock; all state advances once per frame.
- Reset  in  1  asynchronous active-high reset.
- game_state  in  2  top-level state; 2'b01 = RUN.
- player_x  in  W  player screen X centre.
- player_y  in  W  player screen Y centre.
- player_falling  in  1  player vertical velocity is downward this frame.
- background_offset  in  W  scroll offset (global = screen + offset).
- enemy_x_rel  out  W  enemy screen X (global − background_offset), combinational.
- enemy_y_rel  out  W  enemy screen Y, combinational.
- is_right  out  1  current facing/motion direction.
- visible  out  1  high in WALK or SQUISH.
- squished  out  1  high in SQUISH (renderer selects flat sprite).
- collides  out  1  sticky: player touched the enemy from a non-stomp angle.
- stomp  out  1  one-frame pulse on a successful stomp (score/bounce).

Behaviour:
- Reset is asynchronous and active-high. While Reset is high, or on any frame_clk edge with game_state ≠ 2'b01:
  - state = IDLE, x = START_X, y = START_Y, is_right = START_RIGHT, squish counter = 0, collides = 0, stomp = 0.
- FSM states: IDLE, WALK, SQUISH, DEAD. visible = (WALK|SQUISH); squished = SQUISH.
- IDLE:
  - No motion, no collision checks.
  - Go to WALK on the first frame where background_offset + SPAWN_DIST ≥ START_X, computed in W+1 bits with no wrap.
- WALK, each frame:
  - Moving right: if x + HALF_W + STEP ≥ RIGHT_BOUND, then x ← RIGHT_BOUND − HALF_W and is_right ← 0; else x ← x + STEP.
  - Moving left: if x − HALF_W − STEP ≤ LEFT_BOUND, then x ← LEFT_BOUND + HALF_W and is_right ← 1; else x ← x − STEP.
  - The enemy never leaves [LEFT_BOUND+HALF_W, RIGHT_BOUND−HALF_W].
- Contact is evaluated in WALK only, using the registered (pre-move) position:
  - dx = player_x − enemy_x_rel and dy = player_y − enemy_y_rel, both signed W+1 bits.
  - contact = |dx| ≤ HIT_MARGIN and |dy| ≤ HIT_MARGIN.
  - stomp condition = contact and player_falling and dy ≤ −STOMP_DY.
  - On stomp condition: stomp = 1 for the next frame only, state → SQUISH, counter ← 0, no position update that frame. collides is not set.
  - Else on contact: collides ← 1 (sticky until reset / state exit); enemy keeps walking.
  - Stomp wins if both conditions hold in the same frame.
- SQUISH:
  - No motion, no contact checks.
  - Counter increments each frame. When counter = SQUISH_FRAMES − 1, state → DEAD.
  - Squished sprite is therefore visible for exactly SQUISH_FRAMES frames.
- DEAD:
  - Terminal until reset or game_state leaves RUN.
  - Outputs: visible = 0, squished = 0, no contact.
  - collides holds its value.
- Arithmetic:
  - enemy_x_rel = x − background_offset, modulo 2^W. It wraps when the enemy is off-screen left; the renderer must gate drawing on visible.
  - All bound comparisons are unsigned on global X.
- stomp is a registered pulse: high exactly one frame after the detection frame.
- Asynchronous Reset asserted mid-SQUISH clears the counter and returns to IDLE immediately.

Test Plan:
- Spawn: Reset, game_state=01, background_offset=4800 → stays IDLE, visible=0. Offset=4840 → WALK next frame, visible=1, enemy_x_rel=5540−4840=700.
- Patrol left bounce (START_RIGHT=0), offset=4840: x decrements by 1 per frame.
  - At x=5321, next frame x=5320 and is_right=1.
  - At x=5735, next frame x=5736 and is_right=0.
  - x never leaves [5320, 5736].
- Side hit: enemy_x_rel=300, enemy_y_rel=408; player (270,408), player_falling=0 → collides=1 next frame. Enemy keeps moving. collides stays 1 after the player moves away.
- Stomp: enemy_x_rel=300; player (305,380), player_falling=1 → stomp=1 for exactly one frame, squished=1, collides=0. After 30 frames: visible=0 (DEAD). Further contact has no effect.
- Stomp/edge precedence: player at dy=−8, falling, |dx|=32 → stomp (boundary inclusive). With dy=−7 → collides instead.
- Mode exit: in SQUISH at counter=10, set game_state=00 for one frame → IDLE, x=5540, collides=0. Async Reset pulse between clock edges gives the same result immediately.
